// File: rtl/nibble_serial_sub_20bit_if.sv
// nibble_serial_sub_20bit_if: operand/result handshake bundle; sign exists only with SUB20_ABS_EN
interface nibble_serial_sub_20bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] a;
  logic [19:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] diff;
  logic        bout;
`ifdef SUB20_ABS_EN
  logic        sign;
  modport master(output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, sign);
  modport slave(input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, sign);
`else
  modport master(output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout);
  modport slave(input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout);
`endif
endinterface

// File: rtl/nibble_serial_sub_20bit.sv
// nibble_serial_sub_20bit: A-B-Bin through one 4-bit borrow slice over 5 cycles; SUB20_ABS_EN adds a NEG pass giving |result| and sign
module nibble_serial_sub_20bit (
  input logic clk,
  input logic rst,
  nibble_serial_sub_20bit_if.slave s
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef SUB20_ABS_EN
    NEG,
`endif
    DONE
  } state_t;
  state_t state, state_n;
  logic [19:0] a_r, b_r, diff_r;
  logic [2:0] cnt;
  logic borrow, bout_r, last;
  logic [3:0] x, y;
  logic [4:0] slice;
  logic [4:0] idx;
  assign idx = {cnt, 2'b00};
  assign last = cnt == 3'd4;
`ifdef SUB20_ABS_EN
  assign x = state == NEG ? 4'h0 : a_r[idx +: 4];
  assign y = state == NEG ? diff_r[idx +: 4] : b_r[idx +: 4];
`else
  assign x = a_r[idx +: 4];
  assign y = b_r[idx +: 4];
`endif
  assign slice = {1'b0, x} - {1'b0, y} - {4'b0, borrow};
  assign s.in_ready = state == IDLE && !rst;
  assign s.out_valid = state == DONE;
  assign s.diff = diff_r;
  assign s.bout = bout_r;
`ifdef SUB20_ABS_EN
  assign s.sign = bout_r;
`endif
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // next-state: accept in IDLE, five slice passes per phase, hold result until consumed
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = s.in_valid ? RUN : IDLE;
`ifdef SUB20_ABS_EN
      RUN:  state_n = last ? (slice[4] ? NEG : DONE) : RUN;
      NEG:  state_n = last ? DONE : NEG;
`else
      RUN:  state_n = last ? DONE : RUN;
`endif
      DONE: state_n = s.out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  // datapath: operands latch only on acceptance, diff changes one nibble per slice pass
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      diff_r <= '0;
      cnt <= '0;
      borrow <= 1'b0;
      bout_r <= 1'b0;
    end else if (state == IDLE) begin
      if (s.in_valid) begin
        a_r <= s.a;
        b_r <= s.b;
        borrow <= s.bin;
        cnt <= '0;
      end
    end else if (state != DONE) begin
      diff_r[idx +: 4] <= slice[3:0];
      borrow <= last ? 1'b0 : slice[4];
      cnt <= last ? 3'd0 : cnt + 3'd1;
      if (last && state == RUN) bout_r <= slice[4];
    end
  end
endmodule

// File: tb/tb_nibble_serial_sub_20bit.sv
// tb_nibble_serial_sub_20bit: directed and random operands against an arithmetic reference
module tb_nibble_serial_sub_20bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int failed = 0;
  nibble_serial_sub_20bit_if bus();
  nibble_serial_sub_20bit dut(.clk(clk), .rst(rst), .s(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [19:0] a, input logic [19:0] b, input logic bin, input int stall, input bit poke);
    logic [20:0] raw;
    logic [19:0] exp_diff;
    logic exp_bout;
    int exp_lat, n, w;
    raw = {1'b0, a} - {1'b0, b} - {20'b0, bin};
    exp_bout = raw[20];
    exp_diff = raw[19:0];
    exp_lat = 5;
`ifdef SUB20_ABS_EN
    if (exp_bout) begin
      exp_diff = 20'(0 - raw[19:0]);
      exp_lat = 10;
    end
`endif
    w = 0;
    while (!bus.in_ready && w < 10) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w == 10) check("ready_timeout", 0, 1);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("busy_in_ready", 32'(bus.in_ready), 0);
    for (n = 1; n <= 20; n++) begin
      if (poke && n == 2) begin
        bus.in_valid = 1'b1;
        bus.a = 20'($urandom);
        bus.b = 20'($urandom);
        bus.out_ready = 1'b1;
      end
      if (n == 3) begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.out_valid) break;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("latency", 32'(n), 32'(exp_lat));
    check("diff", 32'(bus.diff), 32'(exp_diff));
    check("bout", 32'(bus.bout), 32'(exp_bout));
`ifdef SUB20_ABS_EN
    check("sign", 32'(bus.sign), 32'(exp_bout));
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_diff", 32'(bus.diff), 32'(exp_diff));
      check("stall_bout", 32'(bus.bout), 32'(exp_bout));
      check("stall_in_ready", 32'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("post_valid", 32'(bus.out_valid), 0);
    check("post_in_ready", 32'(bus.in_ready), 1);
  endtask

  initial begin
    logic [19:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_diff", 32'(bus.diff), 0);
    check("rst_bout", 32'(bus.bout), 0);
    rst = 1'b0;
    #1;
    check("rst_rel_in_ready", 32'(bus.in_ready), 1);
    run_op(20'h12345, 20'h02345, 1'b0, 0, 1'b0);
    run_op(20'h00010, 20'h0000F, 1'b1, 0, 1'b0);
    run_op(20'hFFFFF, 20'hFFFFF, 1'b1, 0, 1'b0);
    run_op(20'h00000, 20'h00001, 1'b0, 0, 1'b0);
    run_op(20'h54321, 20'h54321, 1'b0, 0, 1'b0);
    run_op(20'h0ABCD, 20'hF1234, 1'b0, 4, 1'b1);
    bus.a = 20'h77777;
    bus.b = 20'h11111;
    bus.bin = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_valid", 32'(bus.out_valid), 0);
    check("midrst_diff", 32'(bus.diff), 0);
    #1;
    check("midrst_in_ready", 32'(bus.in_ready), 1);
    run_op(20'h00005, 20'h00003, 1'b0, 0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      ra = 20'($urandom);
      rb = ($urandom_range(0, 4) == 0) ? ra : 20'($urandom);
      run_op(ra, rb, 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
